// File: rtl/frv_lsu_pipe.sv
// Pipelined load/store unit: split request/response phases, up to DEPTH
// accesses in flight, local misalignment trap, flush with bus drain.
module frv_lsu_pipe #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_load,
  input  logic        lsu_store,
  input  logic [1:0]  lsu_width,
  input  logic        lsu_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_a_error,
  output logic        rsp_b_error,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_wen,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_recv,
  output logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_error
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic       load;
    logic [1:0] width;
    logic       sgn;
    logic [1:0] off;
    logic       a_err;
  } ent_t;

  ent_t          fifo [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, bus_cnt, drain;

  ent_t        head;
  logic        a_err_in, head_vld, idle, pop, push, blocked;
  logic [31:0] shifted, ext;

  assign head     = fifo[rp];
  assign a_err_in = (lsu_width == 2'd1 && lsu_addr[0]) ||
                    (lsu_width == 2'd2 && lsu_addr[1:0] != 2'b00);
  assign head_vld = (cnt != '0);
  // idle: neither flushing nor draining stale bus responses
  assign idle     = (drain == '0) && !flush;

  // Local-error head answers immediately; bus head waits for dmem_recv.
  assign rsp_valid   = idle && head_vld && (head.a_err || dmem_recv);
  assign pop         = rsp_valid && rsp_ready;
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign blocked     = (cnt == CW'(DEPTH)) && !pop;
  assign dmem_req    = lsu_valid && !a_err_in && !blocked && idle;
  assign lsu_ready   = !blocked && idle && (a_err_in || dmem_gnt);
  assign push        = lsu_valid && lsu_ready;
  assign dmem_ack    = !idle || (head_vld && !head.a_err && rsp_ready);
  assign rsp_a_error = rsp_valid && head.a_err;
  assign rsp_b_error = rsp_valid && !head.a_err && dmem_error;

  // Neither load nor store is sent as a no-op write (strobes cleared).
  assign dmem_wen  = lsu_store || !lsu_load;
  assign dmem_addr = {lsu_addr[31:2], 2'b00};

  // Byte strobes and lane-replicated write data from width/offset
  always_comb begin
    dmem_strb  = 4'hF;
    dmem_wdata = lsu_wdata;
    case (lsu_width)
      2'd0: begin
        dmem_strb  = 4'b0001 << lsu_addr[1:0];
        dmem_wdata = {4{lsu_wdata[7:0]}};
      end
      2'd1: begin
        dmem_strb  = 4'b0011 << lsu_addr[1:0];
        dmem_wdata = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!lsu_load && !lsu_store) dmem_strb = 4'h0;
  end

  assign shifted = dmem_rdata >> {head.off, 3'b000};

  // Align and extend load data for the head entry
  always_comb begin
    ext = shifted;
    case (head.width)
      2'd0:    ext = {{24{head.sgn & shifted[7]}}, shifted[7:0]};
      2'd1:    ext = {{16{head.sgn & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
    rsp_rdata = (rsp_valid && head.load && !head.a_err && !dmem_error) ? ext : 32'h0;
  end

  // Tracking FIFO, occupancy counters and drain bookkeeping
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      bus_cnt <= '0;
      drain   <= '0;
    end else if (flush) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      bus_cnt <= '0;
      // a response arriving now retires either a draining or a flushed entry
      drain   <= drain + bus_cnt -
                 CW'(dmem_recv && (drain != '0 || bus_cnt != '0));
    end else begin
      if (push) begin
        fifo[wp] <= '{load:  lsu_load && !lsu_store,
                      width: lsu_width,
                      sgn:   lsu_signed,
                      off:   lsu_addr[1:0],
                      a_err: a_err_in};
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      cnt     <= cnt + CW'(push) - CW'(pop);
      bus_cnt <= bus_cnt + CW'(push && !a_err_in) - CW'(pop && !head.a_err);
      if (drain != '0 && dmem_recv) drain <= drain - CW'(1);
    end
  end

endmodule

// File: tb/tb_frv_lsu_pipe.sv
// Directed bench for frv_lsu_pipe: stimulus pushes expected responses into a
// scoreboard queue; a monitor pops and compares on every accepted response.
module tb_frv_lsu_pipe;

  logic        g_clk = 0, g_reset = 1, flush = 0;
  logic        lsu_valid = 0, lsu_ready;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0;
  logic        lsu_load = 0, lsu_store = 0, lsu_signed = 0;
  logic [1:0]  lsu_width = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_a_error, rsp_b_error;
  logic [31:0] rsp_rdata;
  logic        dmem_req, dmem_gnt = 0, dmem_wen, dmem_recv = 0, dmem_ack, dmem_error = 0;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;

  int total = 0, passed = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        a_err;
    logic        b_err;
  } exp_t;
  exp_t sb[$];

  frv_lsu_pipe #(.DEPTH(4), .CW(3)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_width(lsu_width), .lsu_signed(lsu_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_a_error(rsp_a_error), .rsp_b_error(rsp_b_error),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic ld, input logic [1:0] w,
                     input logic sg, input logic [31:0] wd);
    lsu_valid = 1; lsu_addr = addr; lsu_load = ld; lsu_store = !ld;
    lsu_width = w; lsu_signed = sg; lsu_wdata = wd;
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic ae, input logic be);
    exp_t e;
    e.rdata = rd; e.a_err = ae; e.b_err = be;
    sb.push_back(e);
  endtask

  // Monitor: every accepted response must match the oldest expectation
  always @(negedge g_clk) begin
    if (!g_reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp: got rdata %h with empty scoreboard", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_a_error", {31'b0, rsp_a_error}, {31'b0, e.a_err});
        chk("rsp_b_error", {31'b0, rsp_b_error}, {31'b0, e.b_err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks", passed, total);
    $fatal(1);
  end

  initial begin
    // Reset with a stray bus response present
    dmem_recv = 1;
    cyc(); cyc();
    g_reset = 0;
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("reset_cnt", 32'(dut.cnt), 32'd0);
    dmem_recv = 0;
    req(32'h0, 1, 2'd2, 0, 0); dmem_gnt = 1; #1;
    chk("reset_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    lsu_valid = 0;

    // Signed byte and unsigned half loads
    cyc();
    rsp_ready = 1;
    req(32'h1003, 1, 2'd0, 1, 0); #1;
    chk("lb_dmem_req", {31'b0, dmem_req}, 32'd1);
    chk("lb_dmem_addr", dmem_addr, 32'h1000);
    chk("lb_dmem_wen", {31'b0, dmem_wen}, 32'd0);
    expect_rsp(32'hFFFFFF80, 0, 0);
    cyc();
    req(32'h1002, 1, 2'd1, 0, 0); #1;
    chk("lhu_dmem_addr", dmem_addr, 32'h1000);
    expect_rsp(32'h00008011, 0, 0);
    cyc();
    lsu_valid = 0; dmem_recv = 1; dmem_rdata = 32'h80112233; #1;
    chk("load_dmem_ack", {31'b0, dmem_ack}, 32'd1);
    cyc(); cyc();
    dmem_recv = 0;

    // Half store with bus error on its response
    req(32'h2002, 0, 2'd1, 0, 32'h0000ABCD); #1;
    chk("sh_strb", {28'b0, dmem_strb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_wen", {31'b0, dmem_wen}, 32'd1);
    expect_rsp(32'h0, 0, 1);
    cyc();
    lsu_valid = 0; dmem_recv = 1; dmem_error = 1; dmem_rdata = 32'hDEADBEEF;
    cyc();
    dmem_recv = 0; dmem_error = 0;

    // Misaligned word behind two outstanding loads
    req(32'h4000, 1, 2'd2, 0, 0); expect_rsp(32'h11111111, 0, 0); cyc();
    req(32'h4004, 1, 2'd2, 0, 0); expect_rsp(32'h22222222, 0, 0); cyc();
    req(32'h3001, 1, 2'd2, 0, 0); dmem_gnt = 0; #1;
    chk("aerr_no_req", {31'b0, dmem_req}, 32'd0);
    chk("aerr_ready", {31'b0, lsu_ready}, 32'd1);
    expect_rsp(32'h0, 1, 0);
    cyc();
    lsu_valid = 0; dmem_gnt = 1; #1;
    chk("aerr_wait_older", {31'b0, rsp_valid}, 32'd0);
    dmem_recv = 1; dmem_rdata = 32'h11111111; cyc();
    dmem_rdata = 32'h22222222; cyc();
    dmem_recv = 0; cyc(); cyc();
    chk("aerr_sb_empty", 32'(sb.size()), 32'd0);

    // Fill to DEPTH, then push alongside a pop while full
    for (int i = 0; i < 4; i++) begin
      req(32'h5000 + 32'(4 * i), 1, 2'd2, 0, 0);
      expect_rsp(32'hA0000000 + 32'(i), 0, 0);
      cyc();
    end
    req(32'h5010, 1, 2'd2, 0, 0); #1;
    chk("full_not_ready", {31'b0, lsu_ready}, 32'd0);
    chk("full_no_req", {31'b0, dmem_req}, 32'd0);
    dmem_recv = 1; dmem_rdata = 32'hA0000000; #1;
    chk("full_pop_ready", {31'b0, lsu_ready}, 32'd1);
    expect_rsp(32'hA0000004, 0, 0);
    cyc();
    lsu_valid = 0; dmem_recv = 0; #1;
    chk("full_cnt_kept", 32'(dut.cnt), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      dmem_recv = 1; dmem_rdata = 32'hA0000000 + 32'(i);
      cyc();
    end
    dmem_recv = 0;

    // Flush with three loads outstanding, then drain
    for (int i = 0; i < 3; i++) begin
      req(32'h6000 + 32'(4 * i), 1, 2'd2, 0, 0);
      cyc();
    end
    lsu_valid = 0; flush = 1;
    cyc();
    flush = 0; #1;
    chk("flush_drain", 32'(dut.drain), 32'd3);
    req(32'h6000, 1, 2'd2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      dmem_recv = 1; dmem_rdata = 32'hBAD00000 + 32'(i); #1;
      chk("drain_ack", {31'b0, dmem_ack}, 32'd1);
      chk("drain_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("drain_not_ready", {31'b0, lsu_ready}, 32'd0);
      cyc();
    end
    dmem_recv = 0; #1;
    chk("drain_done_ready", {31'b0, lsu_ready}, 32'd1);
    expect_rsp(32'h12345678, 0, 0);
    cyc();
    lsu_valid = 0; dmem_recv = 1; dmem_rdata = 32'h12345678;
    cyc();
    dmem_recv = 0;
    cyc(); cyc();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frv_lsu_pipe.md
Name: frv_lsu_pipe

Overview:
Pipelined, parametrised load/store unit for the execute stage. It replaces the single-outstanding LSU: loads and stores are split into a request phase and an in-order response phase, and up to DEPTH bus transactions can be in flight at once. Misaligned accesses are trapped locally without touching the bus. A flush drains and discards stale bus responses so that the pipeline can restart cleanly.

Parameters:
DEPTH, 4, max in-flight accesses (bus + local-error entries); power of 2, >=2
CW, 3, width of counters; must satisfy 2^CW > DEPTH

Ports:
g_clk  in  1  global clock
g_reset  in  1  synchronous, active-high reset
flush  in  1  discard all in-flight accesses
lsu_valid  in  1  request valid
lsu_ready  out  1  request accepted this cycle (when lsu_valid)
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data (LSB-aligned)
lsu_load  in  1  load op
lsu_store  in  1  store op
lsu_width  in  2  0=byte 1=half 2=word
lsu_signed  in  1  sign-extend loaded data
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  aligned, extended load data; 0 for stores or errors
rsp_a_error  out  1  misaligned address
rsp_b_error  out  1  bus error
dmem_req  out  1  bus request
dmem_gnt  in  1  bus accepts request
dmem_wen  out  1  write
dmem_strb  out  4  byte strobes
dmem_addr  out  32  word address {lsu_addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated write data
dmem_recv  in  1  bus response valid
dmem_ack  out  1  response accepted
dmem_rdata  in  32  read data
dmem_error  in  1  bus error on response

Behaviour:
- Tracking FIFO, DEPTH entries. Each entry holds {load, width, signed, addr[1:0], a_err}. Counters: cnt (entries), bus_cnt (non-a_err entries), drain.
- a_err = (width==1 && addr[0]) || (width==2 && addr[1:0]!=0).
- Request rules:
  - dmem_req = lsu_valid && !a_err && !full && !flush && drain==0.
  - lsu_ready = !full && !flush && drain==0 && (a_err || dmem_gnt).
  - An entry is pushed when lsu_valid && lsu_ready. a_err requests never assert dmem_req.
- Strobes:
  - byte: 1<<addr[1:0]
  - half: 3<<addr[1:0]
  - word: 4'hF
  - dmem_wen = lsu_store.
  - wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as is.
- Response path (combinational from head; zero added latency):
  - If the head has a_err: rsp_valid=1, rsp_a_error=1, rdata=0, no bus interaction.
  - Otherwise rsp_valid = dmem_recv && drain==0, and dmem_ack = rsp_ready.
  - Pop on rsp_valid && rsp_ready.
  - Load data: shift dmem_rdata right by 8*addr[1:0], then zero- or sign-extend per width/signed.
  - rsp_b_error = dmem_error for bus entries; rdata=0 when b_error is set.
- Ordering: responses return strictly in request order. Local-error entries wait behind older bus entries.
- Full = cnt==DEPTH. Push and pop in the same cycle keep cnt unchanged and are allowed when full (the pop frees the slot). Pointers wrap modulo DEPTH.
- Flush:
  - While flush: rsp_valid=0, dmem_req=0, lsu_ready=0, dmem_ack=1.
  - Next cycle: FIFO empty, cnt=bus_cnt=0, and drain <= drain + bus_cnt - (dmem_recv?1:0).
- Drain:
  - While drain!=0: dmem_ack=1, and each dmem_recv decrements drain with its data discarded. No new requests are accepted.
  - Flush asserted again during drain accumulates correctly via the same formula.
- Reset: all registers cleared; all outputs 0 except lsu_ready, which follows its equation (cnt=0, drain=0). Reset mid-transaction abandons the bus. The bus is required to be reset concurrently.
- Neither lsu_load nor lsu_store set with lsu_valid: the request is treated as a store with strb=0 (no-op write). The response is delivered normally.

Test Plan:
- Reset: assert g_reset with dmem_recv=1 -> next cycle rsp_valid=0, dmem_req=0, cnt=0; lsu_ready=1 for an aligned request with dmem_gnt=1.
- Byte load signed: addr=0x1003, dmem_rdata=0x80112233 -> strb unused, dmem_addr=0x1000, rsp_rdata=0xFFFFFF80. Unsigned half at 0x1002 -> 0x00008011.
- Store half at 0x2002, wdata=0xABCD -> dmem_strb=4'b1100, dmem_wdata=0xABCDABCD, dmem_wen=1.
- Misaligned word at 0x3001 issued behind two outstanding loads -> no dmem_req for it; rsp order: load, load, then a_error=1 with rdata=0.
- Fill DEPTH=4 loads with no dmem_recv -> 5th request sees lsu_ready=0; first response plus simultaneous push -> cnt stays 4 and the push is accepted.
- 3 loads outstanding, flush for 1 cycle with no recv -> drain=3; next 3 dmem_recv are acked with rsp_valid=0; lsu_ready returns to 1 after the third.
